// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide stage with registered reg-bank write
// Define MULDIV_SIGNED_EN to honour sgn (two's-complement operands and results).
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [0:1]  op,
   input  logic        sgn,
   input  logic [0:31] opA,
   input  logic [0:31] opB,
   input  logic [0:4]  dest,
   output logic        busy,
   output logic        done,
   output logic [0:31] busC,
   output logic [0:4]  busCsel,
   output logic        WriteC
);
   typedef enum logic [1:0] {IDLE, CALC, RES, WB} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [1:0]  op_q;
   logic [4:0]  dest_q;
   logic [31:0] b_q;
   logic [63:0] acc_q, acc_d;
   logic [31:0] rem_q, rem_d;
   logic        busy_q, done_q, wr_q;
   logic [31:0] busc_q, res_d;
   logic [4:0]  buscsel_q;
   logic [31:0] opa_w, opb_w, a_in, b_in;
   logic [32:0] sum, rem_sh, diff;
   logic [63:0] prod;
   logic [31:0] quo, rmd;
   logic        accept;

   assign opa_w  = opA;
   assign opb_w  = opB;
   // IDLE with busy still set is the clean-up edge after WB; start is not sampled there.
   assign accept = (state_q == IDLE) && !busy_q && start;

`ifdef MULDIV_SIGNED_EN
   logic neg_res_q, neg_a_q, bzero_q;
   logic sa, sb;
   assign sa   = sgn & opa_w[31];
   assign sb   = sgn & opb_w[31];
   assign a_in = sa ? (~opa_w + 32'd1) : opa_w;
   assign b_in = sb ? (~opb_w + 32'd1) : opb_w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         neg_res_q <= 1'b0;
         neg_a_q   <= 1'b0;
         bzero_q   <= 1'b0;
      end else if (accept) begin
         neg_res_q <= sa ^ sb;
         neg_a_q   <= sa;
         bzero_q   <= (opb_w == 32'd0);
      end
   end
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
   assign a_in       = opa_w;
   assign b_in       = opb_w;
`endif

   // acc low half holds multiplier (MUL) or dividend/quotient (DIV); b_q holds the other operand.
   always_comb begin
      sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      rem_sh = {rem_q, acc_q[31]};
      diff   = rem_sh - {1'b0, b_q};
      acc_d  = {sum, acc_q[31:1]};
      rem_d  = rem_q;
      if (op_q[1]) begin
         acc_d = {32'd0, acc_q[30:0], ~diff[32]};
         rem_d = diff[32] ? rem_sh[31:0] : diff[31:0];
      end
   end

   always_comb begin
      prod = acc_q;
      quo  = acc_q[31:0];
      rmd  = rem_q;
`ifdef MULDIV_SIGNED_EN
      if (neg_res_q) begin
         prod = ~acc_q + 64'd1;
         quo  = ~acc_q[31:0] + 32'd1;
      end
      if (bzero_q) quo = 32'hFFFF_FFFF;
      if (neg_a_q) rmd = ~rem_q + 32'd1;
`endif
      case (op_q)
         2'b00:   res_d = prod[31:0];
         2'b01:   res_d = prod[63:32];
         2'b10:   res_d = quo;
         default: res_d = rmd;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         op_q      <= 2'b00;
         dest_q    <= 5'd0;
         b_q       <= 32'd0;
         acc_q     <= 64'd0;
         rem_q     <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
         busc_q    <= 32'd0;
         buscsel_q <= 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               wr_q   <= 1'b0;
               busy_q <= 1'b0;
               if (accept) begin
                  op_q    <= op;
                  dest_q  <= dest;
                  b_q     <= b_in;
                  acc_q   <= {32'd0, a_in};
                  rem_q   <= 32'd0;
                  cnt_q   <= 5'd0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= RES;
            end
            RES: begin
               busc_q    <= res_d;
               buscsel_q <= dest_q;
               state_q   <= WB;
            end
            WB: begin
               done_q  <= 1'b1;
               wr_q    <= (dest_q != 5'd0);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign WriteC  = wr_q;
   assign busC    = busc_q;
   assign busCsel = buscsel_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution stage for the CPU datapath. Consumes the two operands the register bank drives on busA/busB and computes a 32-bit product half, quotient, or remainder over a fixed 32-iteration sequence. Returns the result to the register bank's write port (busC/busCsel/WriteC) as a clean, registered write pulse. Signals occupancy to the control unit through busy/done.

## Interface
- No parameters; width fixed at 32-bit data and 5-bit register select.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  [0:1]  00 MUL (low 32 of product), 01 MULH (high 32), 10 DIV (quotient), 11 REM (remainder).
- sgn  in  1  signed operation; honoured only when MULDIV_SIGNED_EN is defined.
- opA  in  [0:31]  multiplicand/dividend, driven from reg-bank busA.
- opB  in  [0:31]  multiplier/divisor, driven from reg-bank busB.
- dest  in  [0:4]  destination register index.
- busy  out  1  high from the accepting edge until return to IDLE.
- done  out  1  one-cycle pulse, coincident with the write cycle.
- busC  out  [0:31]  result to reg-bank write data.
- busCsel  out  [0:4]  result destination to reg-bank write select.
- WriteC  out  1  write strobe; reg bank captures on its rising edge.
- Bit 0 is MSB on all vectors.

## Operation
- FSM: IDLE -> CALC -> RES -> WB -> IDLE.
- IDLE: on clk edge with start=1, latch opA, opB, op, sgn, dest; clear accumulator/remainder; iteration counter := 0; go to CALC. start with busy=1 is ignored. It is neither queued nor errored.
- CALC: exactly 32 iterations, one per cycle.
  - MUL/MULH: shift-add, 64-bit product.
  - DIV/REM: restoring divide, 33-bit partial remainder.
  - Counter reaches 31 -> RES.
- RES: busC := selected result, busCsel := latched dest; WriteC stays 0, so data is stable one full cycle before the strobe.
- WB: WriteC=1 and done=1 for exactly one cycle; busC/busCsel held.
- Return to IDLE: WriteC=0, busy=0; busC/busCsel hold their last value until the next RES.
- dest=0: full sequence runs and done pulses; WriteC stays 0.
- Divide by zero (opB=0): quotient 0xFFFFFFFF, remainder = opA; latency unchanged.
- Reset (any time, including mid-CALC): FSM -> IDLE, busy=0, done=0, WriteC=0, busC=0, busCsel=0, internal registers 0. An aborted operation produces no write.

## Timing
- Edge E0 accepts start; busy=1 after E0.
- CALC occupies edges E1..E32.
- E33: busC/busCsel valid.
- E34: WriteC=1, done=1.
- E35: WriteC=0, done=0, busy=0.
- Next start is accepted at E36 at the earliest (start sampled at E35 is ignored because busy is still high on that edge's input).
- All outputs are registered; no combinational path from inputs to outputs.
- opA/opB/dest may change freely after E0.

## Configuration
- MULDIV_SIGNED_EN defined: sgn=1 gives two's-complement semantics. Operands are abs-converted on accept and result sign is corrected in RES, so latency is identical.
  - MULH returns the signed high half.
  - DIV truncates toward zero.
  - REM takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = opA.
- MULDIV_SIGNED_EN undefined: sgn is ignored and all ops are unsigned; no sign logic is synthesised.

## Test plan
- MUL, opA=0x0001_0003, opB=0x0002_0005, dest=7 -> at E33 busC=0x000B_000F, busCsel=7; WriteC one-cycle pulse at E34; busy low after E35.
- MULH, opA=opB=0xFFFF_FFFF, sgn=0 -> busC=0xFFFF_FFFE. With MULDIV_SIGNED_EN and sgn=1 -> busC=0x0000_0000.
- DIV then REM, opA=100, opB=7 -> 14, then 2. opB=0 -> DIV 0xFFFF_FFFF, REM 100.
- Signed (MULDIV_SIGNED_EN): DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF.
- dest=0 -> done pulses at E34, WriteC never rises. start held high throughout -> second operation accepted at E36, not before.
- reset low at E10 mid-CALC -> busy, WriteC, done, busC, busCsel all 0 immediately; no WriteC pulse afterwards. New start after reset release runs a full 35-edge operation.
